median3_stream_ctrl: RTL and testbench

- Streaming 3-tap median filter controller built around the existing combinational 3-input 8-bit median datapath (one instance, inputs a0/a1/a2, output Out).
- Accepts a framed sample stream over valid/ready, maintains the sliding window and sequences the median unit.
- Emits one filtered sample per input sample, with edge replication at frame start and end.
- Sits between a sample source and any downstream consumer.

---
 rtl/median3_stream_ctrl_if.sv | 35 +++
 rtl/median3_stream_ctrl.sv | 142 ++++++++++++++
 tb/tb_median3_stream_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/median3_stream_ctrl_if.sv
// Handshake bundle for median3_stream_ctrl: framed sample input and filtered output.
// MEDIAN_BYPASS_EN adds the bypass select that returns the centre sample instead of the median.
interface median3_stream_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [CNT_W-1:0]  out_idx;
`ifdef MEDIAN_BYPASS_EN
  logic              bypass;
`endif

  modport master (
`ifdef MEDIAN_BYPASS_EN
    output bypass,
`endif
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_idx
  );

  modport slave (
`ifdef MEDIAN_BYPASS_EN
    input  bypass,
`endif
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_idx
  );
endinterface

// File: rtl/median3_stream_ctrl.sv
// Streaming 3-tap median filter with edge replication at frame start and end.
// Optional MEDIAN_BYPASS_EN: bypass=1 outputs the centre sample of the window instead of the median.
module median3_unit #(
  parameter int W = 8
) (
  input  logic [W-1:0] a0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] a2,
  output logic [W-1:0] out
);
  logic [W-1:0] lo01;
  logic [W-1:0] hi01;
  logic [W-1:0] hi_min;

  // median = max(min(a0,a1), min(max(a0,a1), a2))
  always_comb begin
    lo01   = (a0 < a1) ? a0 : a1;
    hi01   = (a0 < a1) ? a1 : a0;
    hi_min = (hi01 < a2) ? hi01 : a2;
    out    = (lo01 > hi_min) ? lo01 : hi_min;
  end
endmodule

module median3_stream_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  median3_stream_ctrl_if.slave  s
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] w0_q, w0_d;
  logic [DATA_W-1:0] w1_q, w1_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [CNT_W-1:0]  out_idx_q, out_idx_d;

  logic              slot_free;
  logic              out_fire;
  logic              in_ready;
  logic              in_fire;
  logic [DATA_W-1:0] med_a2;
  logic [DATA_W-1:0] med_out;
  logic [DATA_W-1:0] result;

  assign slot_free = !out_valid_q || s.out_ready;
  assign out_fire  = out_valid_q && s.out_ready;
  assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == RUN) && slot_free));
  assign in_fire   = s.in_valid && in_ready;

  // In FLUSH the missing right neighbour is the replicated last sample.
  assign med_a2 = (state_q == FLUSH) ? w1_q : s.in_data;

  median3_unit #(.W(DATA_W)) u_median (
    .a0  (w0_q),
    .a1  (w1_q),
    .a2  (med_a2),
    .out (med_out)
  );

`ifdef MEDIAN_BYPASS_EN
  assign result = s.bypass ? w1_q : med_out;
`else
  assign result = med_out;
`endif

  assign s.in_ready  = in_ready;
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign s.out_last  = out_last_q;
  assign s.out_idx   = out_idx_q;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    w0_d        = w0_q;
    w1_d        = w1_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_idx_d   = out_idx_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
      out_idx_d   = out_last_q ? '0 : out_idx_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (in_fire) begin
          w0_d    = s.in_data;
          w1_d    = s.in_data;
          state_d = s.in_last ? FLUSH : RUN;
        end
      end
      RUN: begin
        if (in_fire) begin
          out_data_d  = result;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          w0_d        = w1_q;
          w1_d        = s.in_data;
          if (s.in_last) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (slot_free) begin
          out_data_d  = result;
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      w0_q        <= '0;
      w1_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      w0_q        <= w0_d;
      w1_q        <= w1_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
    end
  end
endmodule

// File: tb/tb_median3_stream_ctrl.sv
// Self-checking bench for median3_stream_ctrl: directed frames plus randomized
// valid/ready traffic scored against a per-frame median model with edge replication.
module tb_median3_stream_ctrl;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  median3_stream_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  median3_stream_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } smp_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [CNT_W-1:0]  idx;
  } out_t;

  smp_t tx_q[$];
  out_t exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  function automatic int med3(input int a, input int b, input int c);
    int v[$];
    v.push_back(a);
    v.push_back(b);
    v.push_back(c);
    v.sort();
    return v[1];
  endfunction

  // Model: y[k] = median(x[k-1], x[k], x[k+1]) with the frame ends replicated.
  task automatic add_frame(input int frame[$]);
    int   n;
    int   l;
    int   r;
    smp_t sm;
    out_t ex;
    n = frame.size();
    for (int k = 0; k < n; k++) begin
      l = frame[(k == 0) ? 0 : k - 1];
      r = frame[(k == n - 1) ? n - 1 : k + 1];
      sm.data = DATA_W'(frame[k]);
      sm.last = (k == n - 1);
      tx_q.push_back(sm);
      ex.data = DATA_W'(med3(l, frame[k], r));
      ex.last = (k == n - 1);
      ex.idx  = CNT_W'(k);
      exp_q.push_back(ex);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives tx_q and scores every output transfer against exp_q until both drain.
  task automatic run_traffic(input string name, input int vpct, input int rpct, input int budget);
    int                cyc;
    logic              hold;
    logic [DATA_W-1:0] prev_data;
    logic              prev_last;
    logic [CNT_W-1:0]  prev_idx;
    out_t              ex;
    cyc  = 0;
    hold = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    prev_idx  = '0;
    while ((tx_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      if (tx_q.size() > 0 && int'($urandom_range(99)) < vpct) begin
        bus.in_valid = 1'b1;
        bus.in_data  = tx_q[0].data;
        bus.in_last  = tx_q[0].last;
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = DATA_W'($urandom);
        bus.in_last  = 1'($urandom);
      end
      bus.out_ready = (int'($urandom_range(99)) < rpct);
      @(negedge clk);
      if (hold) begin
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data ||
            bus.out_last !== prev_last || bus.out_idx !== prev_idx) begin
          tests_failed++;
          $display("FAIL %s hold: got v=%b d=%0h l=%b i=%0d expected v=1 d=%0h l=%b i=%0d",
                   name, bus.out_valid, bus.out_data, bus.out_last, bus.out_idx,
                   prev_data, prev_last, prev_idx);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL %s extra output: got d=%0h l=%b i=%0d expected none",
                   name, bus.out_data, bus.out_last, bus.out_idx);
        end else begin
          ex = exp_q.pop_front();
          if (bus.out_data !== ex.data || bus.out_last !== ex.last || bus.out_idx !== ex.idx) begin
            tests_failed++;
            $display("FAIL %s output: got d=%0h l=%b i=%0d expected d=%0h l=%b i=%0d",
                     name, bus.out_data, bus.out_last, bus.out_idx, ex.data, ex.last, ex.idx);
          end
        end
      end
      hold      = (bus.out_valid === 1'b1) && !bus.out_ready;
      prev_data = bus.out_data;
      prev_last = bus.out_last;
      prev_idx  = bus.out_idx;
      if (bus.in_valid && bus.in_ready === 1'b1) void'(tx_q.pop_front());
      step();
      cyc++;
    end
    if (cyc >= budget) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s timeout: got %0d inputs and %0d outputs pending expected 0",
               name, tx_q.size(), exp_q.size());
      tx_q.delete();
      exp_q.delete();
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    step();
  endtask

  task automatic check_outputs_cleared(input string name);
    tests_run++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
        bus.out_last !== 1'b0 || bus.out_idx !== '0) begin
      tests_failed++;
      $display("FAIL %s: got rdy=%b v=%b d=%0h l=%b i=%0d expected all zero",
               name, bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, bus.out_idx);
    end
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
`ifdef MEDIAN_BYPASS_EN
    bus.bypass    = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) step();
    check_outputs_cleared("reset_values");
    rst = 1'b0;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_ready: got %b expected 1", bus.in_ready);
    end
    step();
  endtask

  task automatic test_basic();
    add_frame('{5, 1, 9, 3, 7});
    run_traffic("basic", 100, 100, 100);
    add_frame('{8'h42});
    run_traffic("single", 100, 100, 50);
    add_frame('{8'h00, 8'hFF, 8'h80, 8'h80});
    run_traffic("full_range", 100, 100, 100);
  endtask

  task automatic test_stall();
    add_frame('{10, 20, 30, 40});
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'd10;
    bus.in_last   = 1'b0;
    step();
    bus.in_data = 8'd20;
    step();
    void'(tx_q.pop_front());
    void'(tx_q.pop_front());
    bus.in_data = 8'd30;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 8'd10) begin
        tests_failed++;
        $display("FAIL stall cycle %0d: got rdy=%b v=%b d=%0d expected rdy=0 v=1 d=10",
                 i, bus.in_ready, bus.out_valid, bus.out_data);
      end
      step();
    end
    run_traffic("stall_drain", 100, 100, 100);
  endtask

  task automatic test_back_to_back();
    add_frame('{3, 3, 8});
    add_frame('{6, 2});
    run_traffic("back_to_back", 100, 100, 100);
  endtask

  task automatic test_reset_mid_frame();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'd1;
    bus.in_last   = 1'b0;
    step();
    bus.in_data = 8'd2;
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd3;
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd1) begin
      tests_failed++;
      $display("FAIL pre_reset: got v=%b d=%0d expected v=1 d=1", bus.out_valid, bus.out_data);
    end
    #2;
    rst = 1'b1;
    #1;
    check_outputs_cleared("async_reset");
    step();
    rst = 1'b0;
    #1;
    add_frame('{7, 9});
    run_traffic("after_reset", 100, 100, 100);
  endtask

  task automatic test_random();
    int frame[$];
    for (int f = 0; f < 30; f++) begin
      frame.delete();
      for (int k = 0; k < int'($urandom_range(1, 9)); k++) frame.push_back(int'($urandom_range(255)));
      add_frame(frame);
    end
    run_traffic("random", 70, 60, 3000);
    for (int f = 0; f < 10; f++) begin
      frame.delete();
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) frame.push_back(int'($urandom_range(255)));
      add_frame(frame);
    end
    run_traffic("random_full_rate", 100, 100, 1000);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
